cyx_mem_access_unit: RTL and testbench
======================================

Name: cyx_mem_access_unit

Overview:
Load/store initiator between the nanoMIPS datapath and the single-port word data RAM (32-bit DIN/DOUT, byte address Adr, WrEn, write on posedge clk, combinational read while WrEn=0).
- Accepts word, halfword and byte loads and stores from the core.
- Performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Holds the core via busy until the access finishes.

Parameters:
ADDR_W, 32, core/memory address width
DATA_W, 32, data width (only 32 supported)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous active-high reset
req  in  1  access request, sampled only in IDLE
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 reserved
sext  in  1  loads: 1 sign-extend, 0 zero-extend
addr  in  ADDR_W  byte address
wdata  in  DATA_W  store data, right-aligned for sub-word
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle completion pulse
rdata  out  DATA_W  extended load result, held until next done
err  out  1  valid with done: access rejected
mem_adr  out  ADDR_W  to RAM Adr, always {addr_q[31:2],2'b00}
mem_din  out  DATA_W  to RAM DIN
mem_wren  out  1  to RAM WrEn
mem_dout  in  DATA_W  from RAM DOUT

Behaviour:
- Reset: state=IDLE; busy=0, done=0, err=0, rdata=0, mem_wren=0, mem_adr=0, mem_din=0.
- Request capture: in IDLE, req=1 registers addr/we/size/sext/wdata. req is ignored in every other state. Core holds no fields after acceptance.
- States and transitions:
  - IDLE: load or sub-word store → RD; word store → WR.
  - RD: mem_wren=0; mem_dout captured into word_q at end of cycle. Load → DONE; sub-word store → WR.
  - WR: mem_wren=1; mem_din=merged word; RAM writes on the exiting edge → DONE.
  - DONE: done=1 → IDLE. req may be accepted the cycle after DONE.
- Latency (req-sampling edge to done high):
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Lanes are little-endian:
  - byte k=addr[1:0] occupies bits [8k+7:8k]
  - half at addr[1] occupies bits [16h+15:16h]
- Merge: word_q with only the selected lane replaced by wdata low bits. Other lanes are unchanged bit-exact.
- Load extend: selected lane, sign- or zero-extended to 32 per sext. Word loads ignore sext. rdata updates at entry to DONE.
- Stores leave rdata unchanged.
- mem_wren is high only in WR, never in RD/IDLE/DONE.
- Reset mid-operation:
  - rst in RD or DONE: no write occurs.
  - rst asserted in WR: the RAM write at that edge still completes.
  - In all cases the next cycle is IDLE with reset outputs and no done.
- size=11 is treated as word when the trap feature is absent.

Optional Feature:
CYX_MAU_MISALIGN_TRAP_EN
- Defined: a half with addr[0]=1, a word with addr[1:0]!=0, or size=11 goes IDLE→DONE directly. err=1 with done, no memory cycle, mem_wren stays 0, rdata unchanged. Latency 1 cycle.
- Undefined: err is tied 0; low address bits below the access size are ignored (forced-aligned access).

Decomposition:
- Shared package cyx_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state encodings ST_IDLE/ST_RD/ST_WR/ST_DONE
  - lane-select helper constants
- One natural sub-module: cyx_lane_align. It is purely combinational and implements both the merge (word, wdata, size, addr[1:0] → merged) and the extract/extend (word, size, sext, addr[1:0] → rdata), so each can be tested standalone.

Test Plan:
1. RAM word@0x4=0x00000005; load word addr=0x4 → mem_adr=0x4, mem_wren=0 throughout, done 2 cycles after req, rdata=0x00000005, err=0.
2. RAM word@0x8=0xFFFFFFFF; store byte 0xAB addr=0x9 → RD then WR, mem_din=0xFFFFABFF, done at cycle 3; a following load word returns 0xFFFFABFF.
3. RAM@0x0=0x80FF7F01; load byte addr=0x2 sext=1 → 0xFFFFFFFF; sext=0 → 0x000000FF; load half addr=0x2 sext=1 → 0xFFFF80FF.
4. Store word 0x12345678 at 0xC → mem_wren high exactly 1 cycle; done after 2 cycles; req pulses during busy are ignored, with no extra done.
5. rst asserted in RD of a sub-word store → no mem_wren pulse, busy=0 next cycle, target word unchanged.
6. Macro defined: load word addr=0x6 → done+err after 1 cycle, mem_wren=0, rdata unchanged. Macro undefined: same access reads word 0x4 with err=0.

Source files
------------

// File: rtl/cyx_mem_pkg.sv
// Shared encodings and lane helpers for the nanoMIPS memory access unit.
// Optional misalignment trapping is selected by the CYX_MAU_MISALIGN_TRAP_EN macro.
package cyx_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int         LANE_W        = 8;
    localparam int         HALF_W        = 16;
    localparam logic [1:0] OFF_HALF_MASK = 2'b10;
    localparam logic [1:0] OFF_WORD_MASK = 2'b00;

    // Reserved size code behaves as a word access when it is not trapped.
    function automatic logic [1:0] eff_size(input logic [1:0] sz);
        return (sz == SZ_RSVD) ? SZ_WORD : sz;
    endfunction

    // Drops the address bits below the access size (forced alignment).
    function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
        logic [1:0] r;
        case (eff_size(sz))
            SZ_BYTE: r = off;
            SZ_HALF: r = off & OFF_HALF_MASK;
            default: r = off & OFF_WORD_MASK;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        return (sz == SZ_RSVD) ||
               ((sz == SZ_HALF) && off[0]) ||
               ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/cyx_lane_align.sv
// Combinational lane logic: merges store data into a RAM word and
// extracts/extends a load lane from a RAM word (little-endian lanes).
module cyx_lane_align
    import cyx_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_sext,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);

    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic [4:0]        w_bit_b;
    logic [4:0]        w_bit_h;
    logic [LANE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    assign w_size  = eff_size(i_size);
    assign w_off   = align_off(i_size, i_off);
    assign w_bit_b = {w_off, 3'b000};
    assign w_bit_h = {w_off[1], 4'b0000};
    assign w_byte  = i_word[w_bit_b +: LANE_W];
    assign w_half  = i_word[w_bit_h +: HALF_W];

    always_comb begin
        o_merged = i_word;
        case (w_size)
            SZ_BYTE: o_merged[w_bit_b +: LANE_W] = i_wdata[LANE_W-1:0];
            SZ_HALF: o_merged[w_bit_h +: HALF_W] = i_wdata[HALF_W-1:0];
            default: o_merged = i_wdata;
        endcase
    end

    // Word loads pass straight through; sext only matters for sub-word lanes.
    always_comb begin
        case (w_size)
            SZ_BYTE: o_rdata = {{(32-LANE_W){i_sext & w_byte[LANE_W-1]}}, w_byte};
            SZ_HALF: o_rdata = {{(32-HALF_W){i_sext & w_half[HALF_W-1]}}, w_half};
            default: o_rdata = i_word;
        endcase
    end

endmodule

// File: rtl/cyx_mem_access_unit.sv
// Load/store initiator between the core and a single-port word RAM.
// Define CYX_MAU_MISALIGN_TRAP_EN to reject misaligned/reserved accesses with err.
module cyx_mem_access_unit
    import cyx_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            r_state;
    state_e            w_next;
    logic              r_we;
    logic              r_sext;
    logic              r_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_word_q;
    logic [DATA_W-1:0] r_rdata;
    logic              w_trap;
    logic              w_accept;
    logic              w_word_op;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_load;

`ifdef CYX_MAU_MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(size, addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    assign w_accept  = (r_state == ST_IDLE) && req;
    assign w_word_op = (eff_size(size) == SZ_WORD);

    // RD extracts straight from the RAM output; WR merges into the captured word.
    assign w_word = (r_state == ST_RD) ? mem_dout : r_word_q;

    cyx_lane_align u_align (
        .i_word   (w_word),
        .i_wdata  (r_wdata),
        .i_size   (r_size),
        .i_off    (r_addr[1:0]),
        .i_sext   (r_sext),
        .o_merged (w_merged),
        .o_rdata  (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_trap) begin
                        w_next = ST_DONE;
                    end else if (we && w_word_op) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD:   w_next = r_we ? ST_WR : ST_DONE;
            ST_WR:   w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != ST_IDLE);
        done     = (r_state == ST_DONE);
        err      = (r_state == ST_DONE) && r_err;
        mem_wren = (r_state == ST_WR);
        mem_din  = (r_state == ST_WR) ? w_merged : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_sext   <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= SZ_BYTE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word_q <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= we;
                r_sext  <= sext;
                r_err   <= w_trap;
                r_size  <= size;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == ST_RD) begin
                r_word_q <= mem_dout;
                if (!r_we) begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign rdata   = r_rdata;
    assign mem_adr = {r_addr[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_cyx_mem_access_unit.sv
// Bench for cyx_mem_access_unit: byte-lane reference model, scoreboard queue
// and monitor; follows CYX_MAU_MISALIGN_TRAP_EN when it is defined.
module tb_cyx_mem_access_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr;
        logic [31:0] addr;
        logic [31:0] din;
        int          issue_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_adr;
    logic [31:0] mem_din;
    logic        mem_wren;
    logic [31:0] mem_dout;

    logic [31:0] ram     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] last_rdata;
    exp_t        exp_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          wren_total = 0;

    cyx_mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sext     (sext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .mem_adr  (mem_adr),
        .mem_din  (mem_din),
        .mem_wren (mem_wren),
        .mem_dout (mem_dout)
    );

    // Clock / reset block and RAM model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign mem_dout = ram[mem_adr[7:2]];
    always @(posedge clk) if (mem_wren) ram[mem_adr[7:2]] <= mem_din;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Reference model: byte-wise view of memory, computed from the access rules.
    task automatic model(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int nb;
        int off;
        bit trap;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] m;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        trap = 0;
`ifdef CYX_MAU_MISALIGN_TRAP_EN
        trap = (sz == 2'd3) || ((int'(a[1:0]) % nb) != 0);
`endif
        off = (int'(a[1:0]) / nb) * nb;
        w   = ref_mem[a[7:2]];
        e.addr = {a[31:2], 2'b00};
        e.din  = 32'h0;
        e.issue_cyc = cyc;
        if (trap) begin
            e.rdata = last_rdata; e.err = 1'b1; e.lat = 1; e.wr = 0;
        end else if (!wr) begin
            v = w >> (8 * off);
            if (nb < 4) begin
                m = (32'd1 << (8 * nb)) - 32'd1;
                v = v & m;
                if (sx && v[8*nb-1]) v = v | ~m;
            end
            last_rdata = v;
            e.rdata = v; e.err = 1'b0; e.lat = 2; e.wr = 0;
        end else begin
            for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
            ref_mem[a[7:2]] = w;
            e.din = w;
            e.rdata = last_rdata; e.err = 1'b0; e.lat = (nb == 4) ? 2 : 3; e.wr = 1;
        end
    endtask

    // Driver tasks
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("wait_idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    task automatic scramble();
        we    = 1'($urandom_range(0, 1));
        size  = 2'($urandom_range(0, 3));
        sext  = 1'($urandom_range(0, 1));
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd);
        req = 1'b1; we = wr; size = sz; sext = sx; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        scramble();
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input bit noise);
        exp_t e;
        int n;
        wait_idle();
        model(wr, sz, sx, a, wd, e);
        exp_q.push_back(e);
        drive_req(wr, sz, sx, a, wd);
        if (noise) begin
            n = 0;
            while (busy && n < 20) begin
                req = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            req = 1'b0;
        end
    endtask

    // Reset asserted one cycle after acceptance (RD for sub-word, WR for word stores).
    task automatic reset_mid(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                             input string nm);
        exp_t e;
        int w0;
        wait_idle();
        if (sz == 2'd2) model(1'b1, sz, 1'b0, a, wd, e);
        w0 = wren_total;
        drive_req(1'b1, sz, 1'b0, a, wd);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rdata = 32'h0;
        #3;
        check({nm, "_busy"},  {31'b0, busy}, 32'h0);
        check({nm, "_done"},  {31'b0, done}, 32'h0);
        check({nm, "_rdata"}, rdata, 32'h0);
        check({nm, "_wrens"}, wren_total - w0, (sz == 2'd2) ? 32'd1 : 32'd0);
        @(negedge clk);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (mem_wren) wren_total++;
        if (rst) begin
            wr_cnt = 0;
        end else begin
            if (mem_wren) begin
                wr_cnt++;
                check("wren_while_idle", {31'b0, busy}, 32'h1);
                if (exp_q.size() > 0) begin
                    check("mem_adr", mem_adr, exp_q[0].addr);
                    check("mem_din", mem_din, exp_q[0].din);
                end
            end
            if (!done) check("err_without_done", {31'b0, err}, 32'h0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: got done=1 want no done (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata",   rdata, e.rdata);
                    check("err",     {31'b0, err}, {31'b0, e.err});
                    check("latency", cyc - e.issue_cyc, e.lat);
                    check("wr_cycles", wr_cnt, e.wr);
                end
                wr_cnt = 0;
            end
        end
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; addr = 32'h0; wdata = 32'h0;
        last_rdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[1] = 32'h00000005; ref_mem[1] = 32'h00000005;
        ram[2] = 32'hFFFFFFFF; ref_mem[2] = 32'hFFFFFFFF;
        ram[0] = 32'h80FF7F01; ref_mem[0] = 32'h80FF7F01;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #3;
        check("rst_busy",  {31'b0, busy}, 32'h0);
        check("rst_done",  {31'b0, done}, 32'h0);
        check("rst_err",   {31'b0, err}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_wren",  {31'b0, mem_wren}, 32'h0);
        check("rst_adr",   mem_adr, 32'h0);
        check("rst_din",   mem_din, 32'h0);
        @(negedge clk);

        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0);
        issue(1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AB, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0);
        issue(1'b0, 2'd0, 1'b1, 32'h2, 32'h0, 0);
        issue(1'b0, 2'd0, 1'b0, 32'h2, 32'h0, 0);
        issue(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 0);
        issue(1'b1, 2'd2, 1'b0, 32'hC, 32'h12345678, 1);
        issue(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 0);
        reset_mid(2'd0, 32'h11, 32'h000000C3, "rst_in_rd");
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        reset_mid(2'd2, 32'h14, 32'hCAFEF00D, "rst_in_wr");
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0);
        issue(1'b1, 2'd1, 1'b0, 32'h1B, 32'h0000BEEF, 0);
        issue(1'b1, 2'd3, 1'b0, 32'h1D, 32'h0BADBEEF, 0);
        issue(1'b0, 2'd1, 1'b1, 32'h1A, 32'h0, 0);

        for (int i = 0; i < 250; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), $urandom, ($urandom_range(0, 3) == 0));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h0);
        for (int i = 0; i < 64; i++) check("ram_final", ram[i], ref_mem[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
